// File: rtl/signed_mac_pipe.sv
// signed_mac_pipe
//
// Purpose
//   Three-stage multiply-accumulate pipeline. Each input beat carries two
//   WIDTH-bit operands that are multiplied as either two's-complement or
//   unsigned values. The product is then either loaded into an ACC_WIDTH-bit
//   signed accumulator or added to it. On signed overflow of the addition the
//   accumulator saturates (SAT=1) or wraps (SAT=0). Either way the beat's
//   overflow flag is raised.
//
//   Stage 1 registers the operands and per-beat controls.
//   Stage 2 registers the full-precision product, already extended to
//   ACC_WIDTH.
//   Stage 3 holds the accumulator together with out_valid, out_data and out_ovf.
//
// Handshake (both sides)
//   A beat moves across an interface on a rising clk edge where valid and
//   ready are both high. Valid must not depend on ready. Ready on the input
//   side is purely a function of the output side (stall = out_valid &&
//   !out_ready, in_ready = !stall) and never looks at in_valid. While stalled
//   every stage holds, including valid bits, data, accumulator and flags, so
//   no beat is lost, duplicated or reordered.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   input beat presented
//   in_ready   block accepts the beat this cycle
//   a, b       WIDTH-bit multiplicand / multiplier
//   is_signed  1 = two's-complement operands, 0 = unsigned operands
//   acc_en     1 = add product to accumulator, 0 = load product
//   out_valid  result presented
//   out_ready  consumer accepts the result
//   out_data   ACC_WIDTH-bit signed accumulator value after this beat
//   out_ovf    this beat's accumulate overflowed
//
// Parameters
//   WIDTH      operand width, 2..32
//   ACC_WIDTH  accumulator/result width, at least 2*WIDTH+1
//   SAT        1 = saturate on overflow, 0 = wrap

module signed_mac_pipe #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+8,
   parameter int SAT       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   input  logic                 acc_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_ovf
);

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   // ---------------------------------------------------------------------
   // Flow control: one global advance enable shared by every stage.
   // ---------------------------------------------------------------------
   logic stall;
   logic advance;

   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = advance;

   // ---------------------------------------------------------------------
   // Stage 1: operands and per-beat controls
   // ---------------------------------------------------------------------
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_signed;
   logic             s1_acc_en;

   // ---------------------------------------------------------------------
   // Stage 2: extended product
   // ---------------------------------------------------------------------
   logic                 s2_valid;
   logic [ACC_WIDTH-1:0] s2_prod;
   logic                 s2_acc_en;

   // ---------------------------------------------------------------------
   // Stage 3: accumulator (drives out_data directly)
   // ---------------------------------------------------------------------
   logic [ACC_WIDTH-1:0] acc;

   // Both operands are widened by one bit. The extra bit is a copy of the MSB
   // for signed beats and zero for unsigned beats. A single signed multiplier
   // then covers both modes. The (WIDTH+1)x(WIDTH+1) product always fits in
   // 2*WIDTH+2 bits, and its value fits in 2*WIDTH+1 signed bits. The sized
   // cast to ACC_WIDTH therefore sign-extends (or drops only redundant sign
   // bits) without changing the value.
   logic signed [WIDTH:0]       a_ext;
   logic signed [WIDTH:0]       b_ext;
   logic signed [2*WIDTH+1:0]   prod_full;
   logic        [ACC_WIDTH-1:0] prod_ext;

   assign a_ext     = {s1_signed & s1_a[WIDTH-1], s1_a};
   assign b_ext     = {s1_signed & s1_b[WIDTH-1], s1_b};
   assign prod_full = a_ext * b_ext;
   assign prod_ext  = ACC_WIDTH'(prod_full);

   // Accumulate / load decision for the beat sitting in stage 2
   logic [ACC_WIDTH-1:0] sum;
   logic                 add_ovf;
   logic [ACC_WIDTH-1:0] sat_val;
   logic [ACC_WIDTH-1:0] acc_next;
   logic                 ovf_next;

   assign sum = acc + s2_prod;

   // Signed overflow: operands agree in sign and the sum disagrees.
   assign add_ovf = (acc[ACC_WIDTH-1] == s2_prod[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

   // The clamp direction follows the shared operand sign.
   assign sat_val = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;

   always_comb begin
      acc_next = acc;
      ovf_next = 1'b0;
      if (!s2_acc_en) begin
         acc_next = s2_prod;
      end else if (add_ovf) begin
         ovf_next = 1'b1;
         acc_next = (SAT != 0) ? sat_val : sum;
      end else begin
         acc_next = sum;
      end
   end

   // ---------------------------------------------------------------------
   // Control state with synchronous reset
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         acc       <= '0;
         out_ovf   <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         // A bubble leaves the accumulator untouched. The overflow flag only
         // ever describes the beat currently presented.
         if (s2_valid) begin
            acc     <= acc_next;
            out_ovf <= ovf_next;
         end else begin
            out_ovf <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers: no reset needed, qualified by the valid bits above
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         s1_a      <= a;
         s1_b      <= b;
         s1_signed <= is_signed;
         s1_acc_en <= acc_en;
      end
      if (advance && s1_valid) begin
         s2_prod   <= prod_ext;
         s2_acc_en <= s1_acc_en;
      end
   end

   assign out_data = acc;

endmodule

// File: tb/tb_signed_mac_pipe.sv
// tb_signed_mac_pipe
//
// Bench for signed_mac_pipe. It builds three instances that share every
// input:
//   dut    WIDTH=8, ACC_WIDTH=24, SAT=1
//   dut_s  WIDTH=8, ACC_WIDTH=17, SAT=1
//   dut_w  WIDTH=8, ACC_WIDTH=17, SAT=0
//
// A reference model runs on plain integer arithmetic. Each accepted beat is
// folded into a per-instance accumulator. The resulting {ovf, value} is pushed
// onto an expected queue, and the head of that queue is compared with every
// output transfer. Directed sequences also check their observed outputs
// against fixed constants.

module tb_signed_mac_pipe;

   localparam int W   = 8;
   localparam int AW  = 2*W+8;
   localparam int AWN = 17;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1);
   end

   // ---------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------
   logic           in_valid  = 1'b0;
   logic [W-1:0]   a         = '0;
   logic [W-1:0]   b         = '0;
   logic           is_signed = 1'b0;
   logic           acc_en    = 1'b0;
   logic           out_ready = 1'b1;

   logic           in_ready, in_ready_s, in_ready_w;
   logic           out_valid, out_valid_s, out_valid_w;
   logic [AW-1:0]  out_data;
   logic [AWN-1:0] out_data_s, out_data_w;
   logic           out_ovf, out_ovf_s, out_ovf_w;

   signed_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf)
   );

   signed_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AWN), .SAT(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_ovf(out_ovf_s)
   );

   signed_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AWN), .SAT(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en),
      .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_ovf(out_ovf_w)
   );

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [63:0] d_of(input logic [64:0] e);
      return $signed(e[63:0]);
   endfunction

   // ---------------------------------------------------------------------
   // Reference model: plain integer arithmetic on the accumulator value
   // ---------------------------------------------------------------------
   function automatic void model(input int aw, input bit sat,
                                 input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input bit sg, input bit ae,
                                 inout longint acc, output bit ovf);
      longint p, s, maxv, minv, span;
      maxv = (longint'(1) <<< (aw-1)) - 1;
      minv = -(longint'(1) <<< (aw-1));
      span = longint'(1) <<< aw;
      if (sg) p = longint'($signed(av)) * longint'($signed(bv));
      else    p = longint'(av) * longint'(bv);
      ovf = 1'b0;
      if (!ae) begin
         acc = p;
      end else begin
         s = acc + p;
         if (s > maxv || s < minv) begin
            ovf = 1'b1;
            if (sat) acc = (s > maxv) ? maxv : minv;
            else     acc = (s > maxv) ? s - span : s + span;
         end else begin
            acc = s;
         end
      end
   endfunction

   // ---------------------------------------------------------------------
   // Scoreboard: expected queues plus logs of observed outputs
   // ---------------------------------------------------------------------
   logic [64:0] exp_q0[$];
   logic [64:0] exp_qs[$];
   logic [64:0] exp_qw[$];
   logic [64:0] obs0[$];
   logic [64:0] obss[$];
   logic [64:0] obsw[$];
   int          obs_cyc[$];
   longint      acc0 = 0, accs = 0, accw = 0;

   task automatic clear_obs();
      obs0.delete(); obss.delete(); obsw.delete(); obs_cyc.delete();
   endtask

   always @(negedge clk) begin
      logic [64:0] e;
      bit          o;
      if (!rst_n) begin
         exp_q0.delete(); exp_qs.delete(); exp_qw.delete();
         acc0 = 0; accs = 0; accw = 0;
      end else begin
         check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         check("in_ready_s", 64'(in_ready_s), 64'(in_ready));
         check("in_ready_w", 64'(in_ready_w), 64'(in_ready));
         check("out_valid_s", 64'(out_valid_s), 64'(out_valid));
         check("out_valid_w", 64'(out_valid_w), 64'(out_valid));
         if (out_valid && out_ready) begin
            if (exp_q0.size() == 0) check("pending0", 64'(out_valid), 64'(0));
            else begin
               e = exp_q0.pop_front();
               check("data0", 64'($signed(out_data)), d_of(e));
               check("ovf0", 64'(out_ovf), 64'(e[64]));
            end
            if (exp_qs.size() == 0) check("pending_s", 64'(out_valid_s), 64'(0));
            else begin
               e = exp_qs.pop_front();
               check("data_s", 64'($signed(out_data_s)), d_of(e));
               check("ovf_s", 64'(out_ovf_s), 64'(e[64]));
            end
            if (exp_qw.size() == 0) check("pending_w", 64'(out_valid_w), 64'(0));
            else begin
               e = exp_qw.pop_front();
               check("data_w", 64'($signed(out_data_w)), d_of(e));
               check("ovf_w", 64'(out_ovf_w), 64'(e[64]));
            end
            obs0.push_back({out_ovf, 64'($signed(out_data))});
            obss.push_back({out_ovf_s, 64'($signed(out_data_s))});
            obsw.push_back({out_ovf_w, 64'($signed(out_data_w))});
            obs_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) begin
            model(AW, 1'b1, a, b, is_signed, acc_en, acc0, o);
            exp_q0.push_back({o, acc0});
            model(AWN, 1'b1, a, b, is_signed, acc_en, accs, o);
            exp_qs.push_back({o, accs});
            model(AWN, 1'b0, a, b, is_signed, acc_en, accw, o);
            exp_qw.push_back({o, accw});
         end
      end
   end

   // ---------------------------------------------------------------------
   // Driver tasks. Each one starts and ends 1 time unit after a rising edge.
   // ---------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input bit sg, input bit ae);
      int guard;
      guard     = 0;
      in_valid  = 1'b1;
      a         = av;
      b         = bv;
      is_signed = sg;
      acc_en    = ae;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("in_ready_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 3))
         0:       return W'(8'h80);
         1:       return W'(8'h7F);
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   bit done;

   initial begin
      // Reset state
      rst_n = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'($signed(out_data)), 64'(0));
      check("rst_out_ovf", 64'(out_ovf), 64'(0));
      check("rst_out_data_s", 64'($signed(out_data_s)), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_valid", 64'(out_valid), 64'(0));
      check("post_rst_ready", 64'(in_ready), 64'(1));

      // (-128)*(-128), load. The result appears in the third cycle after the
      // acceptance cycle.
      clear_obs();
      drive_beat(W'(8'h80), W'(8'h80), 1'b1, 1'b0);
      check("lat_c1_valid", 64'(out_valid), 64'(0));
      idle(1);
      check("lat_c2_valid", 64'(out_valid), 64'(0));
      idle(1);
      check("lat_c3_valid", 64'(out_valid), 64'(1));
      check("lat_c3_data", 64'($signed(out_data)), 64'(16384));
      check("lat_c3_ovf", 64'(out_ovf), 64'(0));
      idle(2);

      // 0xFF*0xFF unsigned, then signed
      clear_obs();
      drive_beat(W'(8'hFF), W'(8'hFF), 1'b0, 1'b0);
      drive_beat(W'(8'hFF), W'(8'hFF), 1'b1, 1'b0);
      idle(5);
      check("ff_count", 64'(obs0.size()), 64'(2));
      if (obs0.size() >= 2) begin
         check("ff_unsigned", d_of(obs0[0]), 64'(65025));
         check("ff_signed", d_of(obs0[1]), 64'(1));
         check("ff_unsigned_17", d_of(obss[0]), 64'(65025));
      end

      // Back-to-back accumulate chain
      clear_obs();
      drive_beat(W'(3), W'(4), 1'b1, 1'b0);
      drive_beat(W'(5), W'(6), 1'b1, 1'b1);
      drive_beat(W'(8'hFE), W'(7), 1'b1, 1'b1);
      idle(5);
      check("chain_count", 64'(obs0.size()), 64'(3));
      if (obs0.size() >= 3) begin
         check("chain_0", d_of(obs0[0]), 64'(12));
         check("chain_1", d_of(obs0[1]), 64'(42));
         check("chain_2", d_of(obs0[2]), 64'(28));
         check("chain_gap_1", 64'(obs_cyc[1] - obs_cyc[0]), 64'(1));
         check("chain_gap_2", 64'(obs_cyc[2] - obs_cyc[1]), 64'(1));
      end

      // 17-bit accumulator: saturate versus wrap
      clear_obs();
      drive_beat(W'(8'h80), W'(8'h80), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive_beat(W'(8'h80), W'(8'h80), 1'b1, 1'b1);
      idle(5);
      check("sat_count", 64'(obss.size()), 64'(4));
      if (obss.size() >= 4) begin
         check("sat_0", d_of(obss[0]), 64'(16384));
         check("sat_1", d_of(obss[1]), 64'(32768));
         check("sat_2", d_of(obss[2]), 64'(49152));
         check("sat_3", d_of(obss[3]), 64'(65535));
         check("sat_ovf_2", 64'(obss[2][64]), 64'(0));
         check("sat_ovf_3", 64'(obss[3][64]), 64'(1));
         check("wrap_3", d_of(obsw[3]), -64'sd65536);
         check("wrap_ovf_3", 64'(obsw[3][64]), 64'(1));
         check("wide_3", d_of(obs0[3]), 64'(65536));
      end

      // Stall: stream 5 beats with out_ready held low for 6 cycles
      clear_obs();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 5; i++) drive_beat(W'(i), W'(i), 1'b1, 1'b0);
         end
         begin
            logic [AW-1:0] held;
            int guard;
            guard = 0;
            while (!out_valid && guard < 20) begin idle(1); guard++; end
            check("stall_valid_seen", 64'(out_valid), 64'(1));
            check("stall_in_ready_low", 64'(in_ready), 64'(0));
            held = out_data;
            for (int k = 0; k < 6; k++) begin
               idle(1);
               check("stall_data_hold", 64'(out_data), 64'(held));
               check("stall_in_ready_hold", 64'(in_ready), 64'(0));
            end
            out_ready = 1'b1;
         end
      join
      idle(6);
      check("stall_count", 64'(obs0.size()), 64'(5));
      for (int i = 0; i < obs0.size() && i < 5; i++)
         check("stall_order", d_of(obs0[i]), 64'((i+1)*(i+1)));

      // Reset while stalled with beats in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive_beat(W'(9), W'(9), 1'b1, 1'b1);
      idle(1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(1);
      check("rst_stall_valid", 64'(out_valid), 64'(0));
      check("rst_stall_data", 64'($signed(out_data)), 64'(0));
      idle(4);

      // One-cycle reset pulse with 3 beats in flight, then an accumulate
      clear_obs();
      for (int i = 0; i < 3; i++) drive_beat(W'(7), W'(5), 1'b1, 1'b1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      check("rst_pulse_valid", 64'(out_valid), 64'(0));
      check("rst_pulse_data", 64'($signed(out_data)), 64'(0));
      check("rst_pulse_ovf", 64'(out_ovf), 64'(0));
      idle(4);
      clear_obs();
      drive_beat(W'(2), W'(3), 1'b1, 1'b1);
      idle(5);
      check("after_rst_count", 64'(obs0.size()), 64'(1));
      if (obs0.size() >= 1) check("after_rst_acc", d_of(obs0[0]), 64'(6));

      // Randomised traffic with random idles and output back-pressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               drive_beat(pick_operand(), pick_operand(),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               idle(1);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      idle(10);

      check("left_q0", 64'(exp_q0.size()), 64'(0));
      check("left_qs", 64'(exp_qs.size()), 64'(0));
      check("left_qw", 64'(exp_qw.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
